cycle_seq: RTL

Parametrised 6502 instruction-cycle sequencer: generates the one-hot timing state `T0..T(NCYC-1)` and the registered `sync` strobe that drive the decode and control logic. It extends the fixed 7-state one-hot sequencer with:
- RDY stall;
- a page-cross cycle skip;
- sticky overrun detection;
- a binary cycle index;
- NMI/IRQ polling at instruction boundaries.

It sits between the decoder (which supplies `next_sync`/`skip`) and the datapath control.

---
 rtl/cycle_seq_pkg.sv | 22 ++
 rtl/cycle_seq_edge_detect.sv | 22 ++
 rtl/cycle_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/cycle_seq_pkg.sv
// Shared constants and helpers for the 6502 instruction-cycle sequencer.
package cycle_seq_pkg;

    // One-hot encoding of the opcode-fetch state
    localparam int unsigned T0 = 1;

    // Widest one-hot vector the index helper accepts
    localparam int unsigned MAX_NCYC = 64;

    // Priority encoder: index of the lowest set bit, 0 when the vector is empty
    function automatic logic [31:0] onehot2idx(input logic [MAX_NCYC-1:0] vec);
        logic [31:0] idx;
        idx = '0;
        for (int i = MAX_NCYC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 32'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cycle_seq_edge_detect.sv
// Rising-edge detector with synchronous reset; the edge output is combinational.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise_c
);

    logic r_prev;

    // Remember last cycle's level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_rise_c = i_d & ~r_prev;

endmodule

// File: rtl/cycle_seq.sv
// One-hot 6502 timing-state sequencer with stall, skip, overrun and interrupt polling.
module cycle_seq
    import cycle_seq_pkg::*;
#(
    parameter int unsigned NCYC = 8,
    parameter int unsigned CW   = $clog2(NCYC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            next_sync,
    input  logic            rdy,
    input  logic            skip,
    input  logic            nmi,
    input  logic            irq,
    input  logic            irq_mask,
    input  logic            int_ack,
    output logic [NCYC-1:0] cycle,
    output logic            cyc_valid,
    output logic [CW-1:0]   cyc_idx,
    output logic            sync,
    output logic            overrun,
    output logic            int_req,
    output logic            int_is_nmi
);

    logic [NCYC-1:0] r_cycle;
    logic            r_cyc_valid;
    logic [CW-1:0]   r_cyc_idx;
    logic            r_sync;
    logic            r_overrun;
    logic            r_int_req;
    logic            r_int_is_nmi;
    logic            r_nmi_pend;

    logic            w_nmi_rise;
    logic [NCYC-1:0] w_cycle_nxt;
    logic            w_poll;
    logic            w_nmi_eff;
    logic            w_irq_eff;

    edge_detect u_nmi_edge (
        .clk      (clk),
        .rst      (rst),
        .i_d      (nmi),
        .o_rise_c (w_nmi_rise)
    );

    // Next timing state for a non-stalled cycle; an empty result means the set bit fell off the end
    always_comb begin
        w_cycle_nxt = '0;
        if (next_sync || (r_cycle == '0)) begin
            w_cycle_nxt = NCYC'(T0);
        end else if (skip) begin
            w_cycle_nxt = r_cycle << 2;
        end else begin
            w_cycle_nxt = r_cycle << 1;
        end
    end

    assign w_poll    = rdy & next_sync;
    assign w_nmi_eff = r_nmi_pend | w_nmi_rise;
    assign w_irq_eff = irq & ~irq_mask;

    // Timing state, sync strobe, overrun flag and interrupt latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle      <= '0;
            r_cyc_valid  <= 1'b0;
            r_cyc_idx    <= '0;
            r_sync       <= 1'b0;
            r_overrun    <= 1'b0;
            r_int_req    <= 1'b0;
            r_int_is_nmi <= 1'b0;
            r_nmi_pend   <= 1'b0;
        end else begin
            if (rdy) begin
                r_cycle     <= w_cycle_nxt;
                r_cyc_valid <= |w_cycle_nxt;
                r_cyc_idx   <= CW'(onehot2idx(MAX_NCYC'(w_cycle_nxt)));
                r_sync      <= next_sync;
                if (w_cycle_nxt == '0) begin
                    r_overrun <= 1'b1;
                end
            end

            if (w_poll) begin
                if (w_nmi_eff) begin
                    r_int_req    <= 1'b1;
                    r_int_is_nmi <= 1'b1;
                    r_nmi_pend   <= 1'b0;
                end else if (w_irq_eff) begin
                    r_int_req    <= 1'b1;
                    r_int_is_nmi <= 1'b0;
                end else begin
                    r_int_req    <= 1'b0;
                    r_int_is_nmi <= 1'b0;
                end
            end else begin
                // Edges outside a poll wait in the pending latch, even during a stall
                if (w_nmi_rise) begin
                    r_nmi_pend <= 1'b1;
                end
                if (rdy && int_ack) begin
                    r_int_req    <= 1'b0;
                    r_int_is_nmi <= 1'b0;
                end
            end
        end
    end

    assign cycle      = r_cycle;
    assign cyc_valid  = r_cyc_valid;
    assign cyc_idx    = r_cyc_idx;
    assign sync       = r_sync;
    assign overrun    = r_overrun;
    assign int_req    = r_int_req;
    assign int_is_nmi = r_int_is_nmi;

endmodule
